rmii_rx: RTL and testbench

RMII_RX -- requirements
Module: rmii_rx

---
 rtl/eth_types_pkg.sv | 46 ++++
 rtl/crc32_d8.sv | 20 ++
 rtl/rmii_rx.sv | 214 +++++++++++++++++++++
 tb/tb_rmii_rx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_types_pkg
//  Description : Shared Ethernet types and constants: RMII receive state
//                encoding, preamble/SFD symbols and CRC-32 parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_types_pkg;

  // Receive state machine encoding
  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_PREAMBLE = 2'd1,
    RX_DATA     = 2'd2,
    RX_DROP     = 2'd3
  } rmii_rx_state_t;

  // Line symbols
  localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
  localparam logic [1:0]  SFD_DIBIT       = 2'b11;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;

  // Reflected Ethernet CRC-32
  localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  // Shortest legal frame, destination MAC through FCS
  localparam logic [10:0] MIN_FRAME_BYTES = 11'd64;

  // Fold one byte into a reflected CRC-32 register, least significant bit first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC32_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_d8
//  Description : Combinational next-state for a byte-wide reflected CRC-32.
//                The caller owns the CRC register.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
  import eth_types_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  // Next CRC value after absorbing one byte
  assign crc_out = crc32_byte(crc_in, data);

endmodule
`default_nettype wire

// File: rtl/rmii_rx.sv
`default_nettype none
// ============================================================================
//  Module      : rmii_rx
//  Description : 100 Mb/s RMII receiver. Hunts preamble/SFD, assembles bytes
//                LSB-first from dibits, checks CRC-32, alignment, rx_er and
//                length, and reports each accepted frame with frame_end.
//  Revision    : 1.0 - initial release
// ============================================================================
module rmii_rx
  import eth_types_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MAX_FRAME_BYTES     = 1522
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  rxd,
  input  logic        crs_dv,
  input  logic        rx_er,
  output logic [7:0]  received_byte,
  output logic        byte_valid,
  output logic        frame_end,
  output logic        frame_ok,
  output logic [10:0] frame_len
);

  localparam int                   PRE_CNT_W   = $clog2(MIN_PREAMBLE_DIBITS + 2);
  localparam logic [PRE_CNT_W-1:0] PRE_CNT_MIN = PRE_CNT_W'(MIN_PREAMBLE_DIBITS);
  localparam logic [PRE_CNT_W-1:0] PRE_CNT_ONE = PRE_CNT_W'(1);
  localparam logic [10:0]          LEN_LIMIT   = 11'(MAX_FRAME_BYTES);

  // Input pipeline: stage 1 is the pin register; stage 2 holds the dibit
  // being classified while stage 1 already shows the following cycle's
  // crs_dv, so a dibit can be judged on its own and its successor's carrier.
  logic [1:0] rxd_s1;
  logic [1:0] rxd_s2;
  logic       crs_s1;
  logic       crs_s2;
  logic       er_s1;
  logic       er_s2;

  // Carrier considered present if crs_dv was high in the dibit's own cycle or
  // the next one; its absence is exactly two consecutive low cycles.
  logic       dibit_is_data;

  rmii_rx_state_t      state;
  logic [PRE_CNT_W-1:0] pre_cnt;
  logic [5:0]           shift_reg;     // three most recent dibits, newest on top
  logic [1:0]           dibit_cnt;     // dibits since the SFD, modulo 4
  logic [10:0]          len_cnt;       // bytes since the SFD, saturating
  logic [10:0]          len_next;
  logic                 err_flag;
  logic                 after_reset;   // first cycle after reset release

  // One-cycle staging between byte assembly and the byte_valid strobe
  logic                 pend_valid;
  logic                 pend_sfd;
  logic [7:0]           pend_byte;

  // Frame-end request, resolved against the CRC one cycle later
  logic                 end_pend;
  logic                 end_bad;

  logic [31:0]          crc;
  logic [31:0]          crc_next;

  assign dibit_is_data = crs_s2 | crs_s1;
  assign len_next      = (len_cnt == 11'h7FF) ? len_cnt : len_cnt + 11'd1;

  crc32_d8 u_crc32_d8 (
    .data    (pend_byte),
    .crc_in  (crc),
    .crc_out (crc_next)
  );

  // Register the RMII pins, then delay one more stage for carrier look-ahead
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_s1 <= 2'b00;
      rxd_s2 <= 2'b00;
      crs_s1 <= 1'b0;
      crs_s2 <= 1'b0;
      er_s1  <= 1'b0;
      er_s2  <= 1'b0;
    end else begin
      rxd_s1 <= rxd;
      crs_s1 <= crs_dv;
      er_s1  <= rx_er;
      rxd_s2 <= rxd_s1;
      crs_s2 <= crs_s1;
      er_s2  <= er_s1;
    end
  end

  // Receive state machine, CRC register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RX_IDLE;
      pre_cnt       <= '0;
      shift_reg     <= '0;
      dibit_cnt     <= '0;
      len_cnt       <= '0;
      err_flag      <= 1'b0;
      after_reset   <= 1'b1;
      pend_valid    <= 1'b0;
      pend_sfd      <= 1'b0;
      pend_byte     <= '0;
      end_pend      <= 1'b0;
      end_bad       <= 1'b0;
      crc           <= '0;
      received_byte <= 8'h00;
      byte_valid    <= 1'b0;
      frame_end     <= 1'b0;
      frame_ok      <= 1'b0;
      frame_len     <= '0;
    end else begin
      after_reset <= 1'b0;
      pend_valid  <= 1'b0;
      pend_sfd    <= 1'b0;
      end_pend    <= 1'b0;

      // Publish the staged byte; the SFD marker is shown but not checksummed
      byte_valid <= pend_valid;
      if (pend_valid) begin
        received_byte <= pend_byte;
      end
      if (pend_valid && !pend_sfd) begin
        crc <= crc_next;
      end

      // Frame verdict uses the CRC after the final byte has been absorbed
      frame_end <= end_pend;
      frame_ok  <= end_pend && !end_bad && (crc == CRC32_RESIDUE) &&
                   (len_cnt >= MIN_FRAME_BYTES) && (len_cnt <= LEN_LIMIT);
      if (end_pend) begin
        frame_len <= len_cnt;
      end

      unique case (state)
        RX_IDLE: begin
          if (dibit_is_data && (rxd_s2 == PREAMBLE_DIBIT)) begin
            state   <= RX_PREAMBLE;
            pre_cnt <= PRE_CNT_ONE;
          end
        end

        RX_PREAMBLE: begin
          if (!dibit_is_data) begin
            state <= RX_DROP;
          end else if (rxd_s2 == PREAMBLE_DIBIT) begin
            if (pre_cnt < PRE_CNT_MIN) begin
              pre_cnt <= pre_cnt + PRE_CNT_ONE;
            end
          end else if ((rxd_s2 == SFD_DIBIT) && (pre_cnt >= PRE_CNT_MIN)) begin
            state      <= RX_DATA;
            dibit_cnt  <= 2'd0;
            len_cnt    <= '0;
            err_flag   <= 1'b0;
            crc        <= CRC32_INIT;
            pend_valid <= 1'b1;
            pend_sfd   <= 1'b1;
            pend_byte  <= SFD_BYTE;
          end else begin
            state <= RX_DROP;
          end
        end

        RX_DATA: begin
          if (!dibit_is_data) begin
            // Partial trailing byte is discarded and marks the frame bad
            state    <= RX_IDLE;
            end_pend <= 1'b1;
            end_bad  <= (dibit_cnt != 2'd0) || err_flag;
          end else begin
            shift_reg <= {rxd_s2, shift_reg[5:2]};
            dibit_cnt <= dibit_cnt + 2'd1;
            if (er_s2) begin
              err_flag <= 1'b1;
            end
            if (dibit_cnt == 2'd3) begin
              len_cnt <= len_next;
              if (len_cnt >= LEN_LIMIT) begin
                // Oversize: report now, swallow the remainder of the frame
                state    <= RX_DROP;
                end_pend <= 1'b1;
                end_bad  <= 1'b1;
              end else begin
                pend_valid <= 1'b1;
                pend_byte  <= {rxd_s2, shift_reg};
              end
            end
          end
        end

        RX_DROP: begin
          if (!dibit_is_data) begin
            state <= RX_IDLE;
          end
        end

        default: begin
          state <= RX_IDLE;
        end
      endcase

      // Carrier already up when leaving reset: never lock mid-frame
      if (after_reset && crs_dv) begin
        state <= RX_DROP;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rmii_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rmii_rx
//  Description : Self-checking bench for rmii_rx. Frames are built from random
//                bytes with a table-driven FCS; expected bytes, verdicts and
//                lengths come from the frame description, not the RTL.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rmii_rx;

  localparam int MAXB = 1522;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rxd = 2'b00;
  logic        crs_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  received_byte;
  logic        byte_valid;
  logic        frame_end;
  logic        frame_ok;
  logic [10:0] frame_len;

  rmii_rx #(
    .MIN_PREAMBLE_DIBITS (8),
    .MAX_FRAME_BYTES     (MAXB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .crs_dv        (crs_dv),
    .rx_er         (rx_er),
    .received_byte (received_byte),
    .byte_valid    (byte_valid),
    .frame_end     (frame_end),
    .frame_ok      (frame_ok),
    .frame_len     (frame_len)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference CRC table and frame under test
  logic [31:0] crc_tab [256];
  logic [7:0]  fr [$];
  logic [7:0]  exp_q [$];

  task automatic build_table();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = (c >> 8) ^ crc_tab[(c[7:0] ^ fr[i])];
    return ~c;
  endfunction

  function automatic bit crc_good();
    int n;
    n = fr.size();
    if (n < 4) return 1'b0;
    return fcs_of(n - 4) == {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
  endfunction

  task automatic make_frame(input int n);
    logic [31:0] f;
    fr.delete();
    for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom));
    f = fcs_of(n - 4);
    fr.push_back(f[7:0]);
    fr.push_back(f[15:8]);
    fr.push_back(f[23:16]);
    fr.push_back(f[31:24]);
  endtask

  // Monitor state
  logic [7:0]  got_q [$];
  int          lat_q [$];
  bit          lat_en = 1'b1;
  int          n_end = 0;
  int          end_cyc = 0;
  int          last_bv = 0;
  logic        end_ok = 1'b0;
  logic [10:0] end_len = '0;

  always @(negedge clk) begin
    if (byte_valid) begin
      got_q.push_back(received_byte);
      last_bv = cyc;
      if (lat_en) begin
        if (lat_q.size() > 0) check_eq("byte_latency", cyc, lat_q.pop_front());
        else check_eq("stray_byte_valid", byte_valid, 1'b0);
      end
    end
    if (frame_end) begin
      n_end++;
      end_ok  = frame_ok;
      end_len = frame_len;
      end_cyc = cyc;
    end
  end

  task automatic drive(input logic [1:0] d, input logic cv, input logic er);
    @(negedge clk);
    rxd = d;
    crs_dv = cv;
    rx_er = er;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_byte_valid"}, byte_valid, 1'b0);
    check_eq({tag, "_frame_end"}, frame_end, 1'b0);
    check_eq({tag, "_frame_ok"}, frame_ok, 1'b0);
    check_eq({tag, "_frame_len"}, frame_len, 11'd0);
    check_eq({tag, "_received_byte"}, received_byte, 8'h00);
  endtask

  // Drive preamble, SFD, frame bytes and optional extra dibits, then idle.
  // The byte whose last dibit is sampled at edge S must strobe at edge S+3.
  task automatic send_frame(input int npre, input int extra, input int er_idx,
                            input bit toggle, input int rst_at);
    int         nd;
    int         j;
    logic       cv;
    logic [7:0] b;
    nd = fr.size() * 4 + extra;
    j  = 0;
    for (int p = 0; p < npre; p++) drive(2'b01, 1'b1, 1'b0);
    drive(2'b11, 1'b1, 1'b0);
    if (lat_en && npre >= 8) lat_q.push_back(cyc + 4);
    for (int i = 0; i < fr.size(); i++) begin
      b = fr[i];
      for (int k = 0; k < 4; k++) begin
        cv = 1'b1;
        if (toggle && j >= nd - 8) cv = ((j - (nd - 8)) % 2) == 1;
        drive(b[2*k +: 2], cv, j == er_idx);
        if (lat_en && npre >= 8 && k == 3 && i < MAXB) lat_q.push_back(cyc + 4);
        if (i == rst_at && k == 0) reset = 1'b1;
        if (i == rst_at && k == 1) begin
          check_outputs_zero("midframe_reset");
          reset = 1'b0;
        end
        j++;
      end
    end
    for (int e = 0; e < extra; e++) begin
      cv = 1'b1;
      if (toggle && j >= nd - 8) cv = ((j - (nd - 8)) % 2) == 1;
      drive(2'($urandom), cv, 1'b0);
      j++;
    end
    repeat (12) drive(2'b00, 1'b0, 1'b0);
  endtask

  task automatic check_result(input bit exp_end, input bit exp_ok, input int exp_len,
                              input bit chk_time);
    int m;
    check_eq("byte_count", got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_eq("byte_value", got_q[i], exp_q[i]);
      if (got_q[i] !== exp_q[i]) break;
    end
    check_eq("frame_end_count", n_end, exp_end ? 1 : 0);
    if (exp_end && n_end > 0) begin
      check_eq("frame_ok", end_ok, exp_ok);
      check_eq("frame_len", end_len, exp_len);
      if (chk_time) check_eq("frame_end_timing", end_cyc, last_bv + 1);
    end
    check_eq("unserved_bytes", lat_q.size(), 0);
    got_q.delete();
    lat_q.delete();
    n_end = 0;
  endtask

  // Predict the outcome of the frame in fr, send it and compare
  task automatic run(input int npre, input int extra, input int er_idx,
                     input bit toggle, input int rst_at);
    int n;
    bit pre_ok;
    bit exp_end;
    bit exp_ok;
    n      = fr.size();
    pre_ok = npre >= 8;
    exp_q.delete();
    if (pre_ok) begin
      exp_q.push_back(8'hD5);
      for (int i = 0; i < n && i < MAXB; i++) exp_q.push_back(fr[i]);
      // a reset one byte-time in cancels the byte still in flight
      if (rst_at >= 0) while (exp_q.size() > rst_at) void'(exp_q.pop_back());
    end
    exp_end = pre_ok && rst_at < 0;
    exp_ok  = pre_ok && n >= 64 && n <= MAXB && extra == 0 && er_idx < 0 && crc_good();
    lat_en  = rst_at < 0;
    send_frame(npre, extra, er_idx, toggle, rst_at);
    check_result(exp_end, exp_ok, n, exp_end && extra == 0 && n <= MAXB);
    lat_en = 1'b1;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  npre;
    int  extra;
    int  er;
    bit  tog;
    int  idx;

    build_table();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Good 64-byte frame after a long preamble
    make_frame(64);
    run(15, 0, -1, 1'b0, -1);
    // Same frame with one payload bit flipped
    fr[10] = fr[10] ^ 8'h04;
    run(15, 0, -1, 1'b0, -1);
    // Short preamble is dropped, then the minimum preamble is accepted
    make_frame(64);
    run(4, 0, -1, 1'b0, -1);
    make_frame(64);
    run(8, 0, -1, 1'b0, -1);
    run(7, 0, -1, 1'b0, -1);
    // One trailing dibit: alignment error
    make_frame(64);
    run(15, 1, -1, 1'b0, -1);
    // crs_dv toggling over the last 8 dibits
    make_frame(72);
    run(15, 0, -1, 1'b1, -1);
    // Reset at byte 20, rest dropped, next frame good
    make_frame(80);
    run(15, 0, -1, 1'b0, 20);
    make_frame(64);
    run(15, 0, -1, 1'b0, -1);
    // Runt with valid FCS, rx_er mid-frame
    make_frame(63);
    run(10, 0, -1, 1'b0, -1);
    make_frame(64);
    run(12, 0, 37, 1'b0, -1);
    // Length limits: exactly the maximum, then one byte over
    make_frame(MAXB);
    run(9, 0, -1, 1'b0, -1);
    make_frame(MAXB + 1);
    run(9, 0, -1, 1'b0, -1);

    // Randomized frames
    for (int t = 0; t < 16; t++) begin
      n = ($urandom % 8 == 0) ? $urandom_range(40, 63) : $urandom_range(64, 160);
      make_frame(n);
      npre = ($urandom % 6 == 0) ? $urandom_range(1, 7) : $urandom_range(8, 24);
      if ($urandom % 4 == 0) begin
        idx = $urandom_range(0, n - 1);
        fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(0, 7));
      end
      extra = ($urandom % 5 == 0) ? $urandom_range(1, 3) : 0;
      er    = ($urandom % 8 == 0) ? $urandom_range(0, n * 4 - 9) : -1;
      tog   = ($urandom % 4) == 0;
      run(npre, extra, er, tog, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
